adder16_operand_deser: RTL
==========================

Name: adder16_operand_deser

Overview:
- Streaming front-end for the 16-input adder tree in the 16-bit datapath.
- Accepts one DWIDTH-bit operand per cycle over a valid/ready handshake.
- Collects 16 operands into a frame, or a zero-padded partial frame on flush.
- Presents the frame as a packed parallel bus with its own valid/ready handshake, so each of the adder's 16 inputs is driven from one slot.

Parameters:
- DWIDTH, 16, operand width in bits.
- NSLOT, 16, operands per frame; must be a power of two, at least 2.
- CWIDTH, 5, width of the fill counter; must satisfy 2^CWIDTH > NSLOT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DWIDTH  operand word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept an operand this cycle.
- flush  input  1  close the current partial frame and zero-pad it.
- out_bus  output  NSLOT*DWIDTH  frame; slot k occupies bits [k*DWIDTH +: DWIDTH].
- out_count  output  CWIDTH  number of real operands in the presented frame (1..NSLOT).
- out_valid  output  1  out_bus holds a complete frame.
- out_ready  input  1  consumer accepts the frame this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately, at any time including mid-frame):
  - state=FILL, cnt=0, all slots=0.
  - out_valid=0, out_count=0, in_ready=1.
  - Any partial frame is discarded.
- States: FILL (collecting operands) and HOLD (presenting a frame).
- in_ready is combinational: 1 in FILL, 0 in HOLD.
- FILL:
  - An operand is accepted on a rising edge where in_valid=1 and in_ready=1.
  - On acceptance, slot[cnt] <= in_data and cnt <= cnt+1.
  - Operands land in arrival order: the first accepted word goes to slot 0.
  - When the accepted word is slot NSLOT-1, on that same edge: state <= HOLD, out_count <= NSLOT, cnt <= 0.
  - out_valid is therefore 1 in the cycle after the 16th acceptance. Latency is 1 cycle; no combinational path from in_data to out_bus.
- flush in FILL, sampled on the same edge as in_valid:
  - Any operand accepted this edge is written first.
  - If the resulting fill count n is between 1 and NSLOT-1: slots n..NSLOT-1 <= 0, out_count <= n, state <= HOLD, cnt <= 0.
  - If the resulting fill count is NSLOT: normal completion; flush has no extra effect.
  - If the resulting fill count is 0 (no operands and none accepted this edge): flush is ignored and no empty frame is produced.
- HOLD:
  - out_valid=1, and out_bus and out_count are stable.
  - in_valid and flush are ignored; in_ready=0, so no operand is lost.
  - On an edge with out_ready=1: state <= FILL, out_valid <= 0.
  - Slot contents are left as they are, not cleared. Stale data is never exposed, because a frame is only presented after every slot has been rewritten or zero-padded.
  - The next operand is accepted on the edge after the handoff at the earliest. Minimum frame period is NSLOT+1 cycles.
- out_ready is ignored in FILL.
- Zero padding keeps the downstream sum equal to the sum of the real operands. The consumer uses out_count, for example for averaging.
- Data is stored bit-exact. There is no arithmetic and no sign handling; two's-complement values pass through unchanged.
- cnt never exceeds NSLOT-1 in FILL; there is no wrap-around path.

Test Plan:
- Full frame: after reset, drive 16 back-to-back words 0x0001..0x0010 with out_ready=0.
  - in_ready drops the cycle after the 16th word.
  - out_valid=1, slot0=0x0001, slot15=0x0010, out_count=16.
  - Frame and in_ready=0 are held for 10 cycles. Pulse out_ready: out_valid=0 and in_ready=1 on the next cycle.
- Flush partial: feed 0x7FFF, 0x8000, 0x0003, then flush alone.
  - out_count=3; slots 0..2 equal those words; slots 3..15=0.
  - The adder output equals 0x0002 (mod 2^16).
- Flush with word: on the edge of the 5th word 0x0005, assert flush together with in_valid.
  - out_count=5, slot4=0x0005, slots 5..15=0.
- Boundary cases:
  - flush with cnt=0: no out_valid.
  - flush together with the 16th word: out_count=16, frame unchanged.
  - in_valid held high during HOLD: no extra acceptances; the next frame starts at slot 0 with the word presented after the handoff.
- Reset mid-operation:
  - Assert rst asynchronously (between clock edges) after 7 words; outputs clear immediately.
  - After release, 16 new words 0xA000..0xA00F form a clean frame with no remnants.
  - Repeat with rst asserted during HOLD: out_valid drops at once.
- Stall on input: toggle in_valid randomly over 40 cycles.
  - Frames contain exactly the accepted words in order.
  - Every out_valid frame has out_count=16 until a flush is issued.

Source files
------------

// File: rtl/adder16_operand_deser.sv
// -----------------------------------------------------------------------------
// adder16_operand_deser
//
// Streaming front-end for the 16-input adder tree. Collects one operand per
// cycle into a frame of NSLOT slots and presents the whole frame as a packed
// parallel bus. A flush closes a partial frame early and zero-pads the unused
// slots, so the downstream sum equals the sum of the real operands.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    operand word
//   in_valid   in_data is valid this cycle
//   in_ready   block accepts an operand this cycle (high while filling)
//   flush      close the current partial frame and zero-pad it
//   out_bus    frame; slot k at bits [k*DWIDTH +: DWIDTH]
//   out_count  number of real operands in the presented frame (1..NSLOT)
//   out_valid  out_bus holds a complete frame
//   out_ready  consumer accepts the frame this cycle
// -----------------------------------------------------------------------------
module adder16_operand_deser #(
  parameter int DWIDTH = 16,
  parameter int NSLOT  = 16,
  parameter int CWIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DWIDTH-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [NSLOT*DWIDTH-1:0] out_bus,
  output logic [CWIDTH-1:0]       out_count,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                        state, state_next;
  logic [CWIDTH-1:0]             cnt;
  logic [NSLOT-1:0][DWIDTH-1:0]  slot_q;

  logic                          accept;
  logic                          full;
  logic                          close_frame;
  logic [CWIDTH-1:0]             fill_n;

  // Fill count after this edge's (possible) acceptance. cnt is at most
  // NSLOT-1 while filling, so fill_n reaches NSLOT at most and fits CWIDTH.
  assign accept = in_valid && (state == FILL);
  assign fill_n = cnt + CWIDTH'(accept);
  assign full   = accept && (cnt == CWIDTH'(NSLOT - 1));

  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign out_bus   = slot_q;

  // A frame closes when the last slot is written, or on a flush that leaves
  // at least one real operand; a flush on an empty frame is ignored.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    close_frame = 1'b0;
    state_next  = state;
    case (state)
      FILL: begin
        close_frame = full || (flush && (fill_n != '0));
        if (close_frame) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_count <= '0;
    end else if (close_frame) begin
      cnt       <= '0;
      out_count <= fill_n;
    end else if (accept) begin
      cnt       <= cnt + 1'b1;
    end
  end

  // Slots are not cleared on handoff: a frame is presented only after every
  // slot has been rewritten or zero-padded, so stale data never shows.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the slot array is reset because the bus is visible at reset and
    // must read as zero; it is small enough to live in flops, not RAM.
    if (rst) begin
      slot_q <= '0;
    end else begin
      for (int k = 0; k < NSLOT; k++) begin
        if (accept && (cnt == CWIDTH'(k)))
          slot_q[k] <= in_data;
        else if (close_frame && (CWIDTH'(k) >= fill_n))
          slot_q[k] <= '0;
      end
    end
  end

endmodule
